// File: rtl/countdown_ctrl_if.sv
// Control/status bundle between the countdown sequencer and its surroundings.
// The master drives the pulses and the preset. The slave (countdown_ctrl) drives the
// digits and status flags.
interface countdown_ctrl_if;

    logic       start_p;
    logic       pause_p;
    logic       clear_p;
    logic [3:0] preset_h;
    logic [3:0] preset_l;
    logic [3:0] TimeH;
    logic [3:0] TimeL;
    logic       tick;
    logic       running;
    logic       done;

    modport master (
        output start_p,
        output pause_p,
        output clear_p,
        output preset_h,
        output preset_l,
        input  TimeH,
        input  TimeL,
        input  tick,
        input  running,
        input  done
    );

    modport slave (
        input  start_p,
        input  pause_p,
        input  clear_p,
        input  preset_h,
        input  preset_l,
        output TimeH,
        output TimeL,
        output tick,
        output running,
        output done
    );

endinterface

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown sequencer with a start/pause/clear state machine.
// It steps the count down once every TICK_DIV cycles spent in RUN.
// It feeds the seven-segment digit inputs and raises done when the count reaches 00.
module countdown_ctrl #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CNT_W    = 26
) (
    input logic            clock,
    input logic            reset,
    countdown_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] PrescLast = CNT_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [3:0]       time_h_q, time_h_d;
    logic [3:0]       time_l_q, time_l_d;
    logic             tick_q, tick_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic [3:0] pre_h, pre_l;
    logic       pre_zero;
    logic [3:0] dec_h, dec_l;
    logic       dec_zero;
    logic       presc_last;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Clamp the preset to legal BCD and flag the 00 start value.
    always_comb begin : preset_clamp
        pre_h    = clamp_bcd(bus.preset_h);
        pre_l    = clamp_bcd(bus.preset_l);
        pre_zero = (pre_h == 4'd0) && (pre_l == 4'd0);
    end

    // One BCD step down. RUN never holds 00, so the tens borrow cannot underflow.
    always_comb begin : bcd_decrement
        dec_h = time_h_q;
        dec_l = time_l_q;
        if (time_l_q != 4'd0) begin
            dec_l = time_l_q - 4'd1;
        end else begin
            dec_l = 4'd9;
            dec_h = time_h_q - 4'd1;
        end
        dec_zero   = (dec_h == 4'd0) && (dec_l == 4'd0);
        presc_last = (presc_q == PrescLast);
    end

    // Next-state logic. clear_p outranks everything, and the tick beats a pause on the same edge.
    always_comb begin : next_state
        state_d  = state_q;
        presc_d  = presc_q;
        time_h_d = time_h_q;
        time_l_d = time_l_q;
        tick_d   = 1'b0;

        if (bus.clear_p) begin
            state_d  = StIdle;
            presc_d  = '0;
            time_h_d = pre_h;
            time_l_d = pre_l;
        end else begin
            case (state_q)
                StIdle: begin
                    presc_d  = '0;
                    time_h_d = pre_h;
                    time_l_d = pre_l;
                    if (bus.start_p) begin
                        state_d = pre_zero ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (presc_last) begin
                        presc_d  = '0;
                        tick_d   = 1'b1;
                        time_h_d = dec_h;
                        time_l_d = dec_l;
                        if (dec_zero) begin
                            state_d = StDone;
                        end else if (bus.pause_p) begin
                            state_d = StPause;
                        end
                    end else begin
                        presc_d = presc_q + CNT_W'(1);
                        if (bus.pause_p) begin
                            state_d = StPause;
                        end
                    end
                end
                StPause: begin
                    // Prescaler stays frozen so RUN time before the next tick is preserved.
                    if (bus.start_p || bus.pause_p) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    time_h_d = 4'd0;
                    time_l_d = 4'd0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        running_d = (state_d == StRun);
        done_d    = (state_d == StDone);
    end

    // State and output registers. Reset is asynchronous and active low.
    always_ff @(posedge clock or negedge reset) begin : regs
        if (!reset) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            time_h_q  <= 4'd0;
            time_l_q  <= 4'd0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            time_h_q  <= time_h_d;
            time_l_q  <= time_l_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.TimeH   = time_h_q;
    assign bus.TimeL   = time_l_q;
    assign bus.tick    = tick_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;

    // Digits stay BCD, and running and done are never high together.
    a_bcd_range : assert property (@(posedge clock) disable iff (!reset)
        (time_h_q <= 4'd9) && (time_l_q <= 4'd9));
    a_status_excl : assert property (@(posedge clock) disable iff (!reset)
        !(running_q && done_q));

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with TICK_DIV = 4.
// A decimal reference model is compared against the DUT one time unit after every rising edge.
// Directed scenarios add literal expectations that pin the model.
module tb_countdown_ctrl;

    localparam int unsigned TD = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    countdown_ctrl_if bus ();

    countdown_ctrl #(
        .TICK_DIV(TD),
        .CNT_W   (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: remaining count as a plain integer 0..99, plus RUN cycles since last step.
    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MPause = 2;
    localparam int MDone  = 3;

    int m_val  = 0;
    int m_runc = 0;
    int m_mode = MIdle;
    bit m_tick = 1'b0;

    function automatic int preset_value(input logic [3:0] h, input logic [3:0] l);
        int hh;
        int ll;
        hh = (h > 4'd9) ? 9 : int'(h);
        ll = (l > 4'd9) ? 9 : int'(l);
        return hh * 10 + ll;
    endfunction

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Advance the model on the same edges the DUT sees.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_val  = 0;
            m_runc = 0;
            m_mode = MIdle;
            m_tick = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (bus.clear_p) begin
                m_mode = MIdle;
                m_runc = 0;
                m_val  = preset_value(bus.preset_h, bus.preset_l);
            end else if (m_mode == MIdle) begin
                m_val  = preset_value(bus.preset_h, bus.preset_l);
                m_runc = 0;
                if (bus.start_p) m_mode = (m_val == 0) ? MDone : MRun;
            end else if (m_mode == MRun) begin
                m_runc = m_runc + 1;
                if (bus.pause_p) m_mode = MPause;
                if (m_runc == TD) begin
                    m_runc = 0;
                    m_val  = m_val - 1;
                    m_tick = 1'b1;
                    if (m_val == 0) m_mode = MDone;
                end
            end else if (m_mode == MPause) begin
                if (bus.start_p || bus.pause_p) m_mode = MRun;
            end
        end
    end

    // Compare every cycle, clear of the edge.
    always @(posedge clock) begin
        #1;
        cmp("m_TimeH", 8'(bus.TimeH), 8'(m_val / 10));
        cmp("m_TimeL", 8'(bus.TimeL), 8'(m_val % 10));
        cmp("m_tick", 8'(bus.tick), 8'(m_tick));
        cmp("m_running", 8'(bus.running), 8'(m_mode == MRun));
        cmp("m_done", 8'(bus.done), 8'(m_mode == MDone));
    end

    task automatic pulse(input bit s, input bit p, input bit c);
        @(negedge clock);
        bus.start_p = s;
        bus.pause_p = p;
        bus.clear_p = c;
        @(negedge clock);
        bus.start_p = 1'b0;
        bus.pause_p = 1'b0;
        bus.clear_p = 1'b0;
    endtask

    function automatic logic [7:0] shown();
        return 8'(bus.TimeH * 10 + bus.TimeL);
    endfunction

    initial begin
        bus.start_p  = 1'b0;
        bus.pause_p  = 1'b0;
        bus.clear_p  = 1'b0;
        bus.preset_h = 4'd2;
        bus.preset_l = 4'd5;

        // Reset held for three cycles, then PRE appears one edge after release.
        repeat (3) @(posedge clock);
        #1;
        cmp("rst_TimeH", 8'(bus.TimeH), 8'd0);
        cmp("rst_TimeL", 8'(bus.TimeL), 8'd0);
        cmp("rst_tick", 8'(bus.tick), 8'd0);
        cmp("rst_running", 8'(bus.running), 8'd0);
        cmp("rst_done", 8'(bus.done), 8'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cmp("rel_TimeH", 8'(bus.TimeH), 8'd2);
        cmp("rel_TimeL", 8'(bus.TimeL), 8'd5);

        // Full run from 12: a tick every 4 cycles with a borrow at 10 -> 09, then done.
        @(negedge clock);
        bus.preset_h = 4'd1;
        bus.preset_l = 4'd2;
        pulse(1'b1, 1'b0, 1'b0);
        cmp("start_running", 8'(bus.running), 8'd1);
        cmp("start_val", shown(), 8'd12);
        for (int k = 1; k <= 12; k++) begin
            repeat (TD) @(posedge clock);
            #1;
            cmp("run_tick", 8'(bus.tick), 8'd1);
            cmp("run_val", shown(), 8'(12 - k));
        end
        cmp("end_done", 8'(bus.done), 8'd1);
        cmp("end_running", 8'(bus.running), 8'd0);
        pulse(1'b1, 1'b0, 1'b0);
        cmp("done_ign_start", 8'(bus.done), 8'd1);
        cmp("done_ign_run", 8'(bus.running), 8'd0);

        // Pause two cycles after the first tick, hold, then resume for two more RUN cycles.
        @(negedge clock);
        bus.preset_h = 4'd0;
        bus.preset_l = 4'd5;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (TD) @(posedge clock);
        #1;
        cmp("p_first_tick", 8'(bus.tick), 8'd1);
        cmp("p_first_val", shown(), 8'd4);
        @(negedge clock);
        @(negedge clock);
        bus.pause_p = 1'b1;
        @(negedge clock);
        bus.pause_p = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        cmp("p_hold_val", shown(), 8'd4);
        cmp("p_hold_running", 8'(bus.running), 8'd0);
        pulse(1'b0, 1'b1, 1'b0);
        cmp("p_resumed", 8'(bus.running), 8'd1);
        repeat (2) @(posedge clock);
        #1;
        cmp("p_resume_tick", 8'(bus.tick), 8'd1);
        cmp("p_resume_val", shown(), 8'd3);

        // Zero preset goes straight to DONE. An invalid BCD preset clamps to 99.
        @(negedge clock);
        bus.preset_h = 4'd0;
        bus.preset_l = 4'd0;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        cmp("zero_done", 8'(bus.done), 8'd1);
        cmp("zero_tick", 8'(bus.tick), 8'd0);
        @(negedge clock);
        bus.preset_h = 4'd12;
        bus.preset_l = 4'd15;
        pulse(1'b0, 1'b0, 1'b1);
        cmp("clamp_TimeH", 8'(bus.TimeH), 8'd9);
        cmp("clamp_TimeL", 8'(bus.TimeL), 8'd9);

        // Clear during RUN at 07 reloads 30. Clear together with start stays in IDLE.
        @(negedge clock);
        bus.preset_h = 4'd3;
        bus.preset_l = 4'd0;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (23 * TD) @(posedge clock);
        #1;
        cmp("clr_at07", shown(), 8'd7);
        pulse(1'b0, 1'b0, 1'b1);
        cmp("clr_val", shown(), 8'd30);
        cmp("clr_running", 8'(bus.running), 8'd0);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        pulse(1'b1, 1'b0, 1'b1);
        cmp("clrstart_running", 8'(bus.running), 8'd0);
        cmp("clrstart_val", shown(), 8'd30);

        // Asynchronous reset while counting clears outputs before the next edge.
        pulse(1'b1, 1'b0, 1'b0);
        repeat (TD + 1) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        cmp("arst_TimeH", 8'(bus.TimeH), 8'd0);
        cmp("arst_TimeL", 8'(bus.TimeL), 8'd0);
        cmp("arst_tick", 8'(bus.tick), 8'd0);
        cmp("arst_running", 8'(bus.running), 8'd0);
        cmp("arst_done", 8'(bus.done), 8'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cmp("arst_reload", shown(), 8'd30);

        repeat (3) @(posedge clock);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
